fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 imem_addr  output  32  fetch address, equal to the current PC.
REQ-007 imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 instr_valid  output  1  instruction available to decode/immediate generation.
REQ-010 instr_ready  input  1  decode consumes the instruction this cycle.
REQ-011 instruction  output  32  fetched instruction word.
REQ-012 instr_pc  output  32  PC of the presented instruction.
REQ-013 redirect_valid  input  1  taken branch/jump from execute.
REQ-014 redirect_pc  input  32  PC of the redirecting instruction.
REQ-015 ImmExt  input  32  sign-extended immediate of the redirecting instruction.

Function
REQ-016 The FSM SHALL have exactly three states: S_REQ (request pending), S_WAIT (one request outstanding), S_OUT (instruction held for decode).
REQ-017 imem_req_valid SHALL be 1 only in S_REQ; instr_valid SHALL be 1 only in S_OUT.
REQ-018 S_REQ: imem_req_valid & imem_req_ready -> S_WAIT; otherwise stay, imem_addr stable.
REQ-019 S_WAIT: imem_rsp_valid -> capture imem_rsp_data into instruction, PC into instr_pc, go S_OUT.
REQ-020 imem_rsp_valid outside S_WAIT SHALL be ignored; at most one request SHALL be outstanding.
REQ-021 Response SHALL be accepted no earlier than the cycle after request acceptance.
REQ-022 S_OUT: instr_valid & instr_ready -> PC <= PC + 4, go S_REQ; otherwise instruction and instr_pc stay stable.
REQ-023 PC + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Redirect target SHALL be (redirect_pc + ImmExt) modulo 2^32 with bits [1:0] forced to 2'b00.
REQ-025 Redirect SHALL take priority over every other event in the same cycle and load PC with the target.
REQ-026 Redirect in S_REQ: stay S_REQ, imem_addr shows the target next cycle; a same-cycle handshake SHALL be treated as not accepted by the fetch unit.
REQ-027 Redirect in S_WAIT: set kill flag, stay S_WAIT; the next response SHALL be discarded, kill cleared, go S_REQ.
REQ-028 Redirect in S_OUT: drop held instruction (instr_valid 0 next cycle, no decode handshake counted), go S_REQ.
REQ-029 Redirect while kill already set SHALL update PC only; a single discard remains pending.
REQ-030 Redirect and response in the same S_WAIT cycle: response discarded, go S_REQ, kill stays clear.
REQ-031 Fetch-to-decode latency SHALL be one cycle from response to instr_valid when no stall occurs.

Reset
REQ-032 While reset is high: state S_REQ, PC = RESET_PC, kill = 0, instr_valid = 0, instruction = 0, instr_pc = 0, imem_req_valid = 0.
REQ-033 imem_req_valid SHALL assert in the first cycle after reset deasserts, with imem_addr = RESET_PC.
REQ-034 Reset in any state, including with a request outstanding, SHALL abandon it; responses before the first new request acceptance SHALL be ignored.

Verification
REQ-035 Straight-line: ready always 1, memory answers next cycle with 0x00000013 -> instr_pc 0x0, 0x4, 0x8, one instruction per 3 cycles.
REQ-036 Decode stall: instr_ready 0 for 5 cycles -> instruction/instr_pc unchanged, no new imem request until handshake.
REQ-037 Branch: redirect_pc 0x100, ImmExt 0xFFFFFFF0 in S_OUT -> next imem_addr 0xF0, held instruction dropped.
REQ-038 Kill: redirect in S_WAIT to 0x200, response 0xDEADBEEF -> never presented; next fetch at 0x200.
REQ-039 Wrap: RESET_PC 0xFFFFFFFC -> second fetch address 0x00000000.
REQ-040 Reset mid-S_WAIT, stale response next cycle -> ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory, decode and redirect bundle for the
//                fetch unit. "master" is the fetch unit, "slave" is the
//                surrounding environment (memory, decode, execute).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ImmExt;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instruction, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc, ImmExt
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instruction, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_pc, ImmExt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding-request instruction fetch unit. Issues
//                a fetch at PC, waits for the word, holds it for decode and
//                advances PC by 4. Taken branches/jumps from execute
//                redirect PC to (redirect_pc + ImmExt) word-aligned and
//                squash any in-flight or held instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam logic [31:0] c_PC_STEP    = 32'd4;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_kill;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // Redirect target is word-aligned; both additions wrap naturally at 32 bits
    assign w_target = (bus.redirect_pc + bus.ImmExt) & c_ALIGN_MASK;
    assign w_pc_inc = r_pc + c_PC_STEP;

    // Valids are state decodes, forced low while reset is held so the
    // request appears in the very first cycle after reset is released
    assign bus.imem_req_valid = (r_state == S_REQ) && !reset;
    assign bus.instr_valid    = (r_state == S_OUT) && !reset;
    assign bus.imem_addr      = r_pc;
    assign bus.instruction    = r_instr;
    assign bus.instr_pc       = r_instr_pc;

    // Fetch FSM: redirect is checked first in every state so it wins over
    // request/response/decode handshakes occurring in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_target;
                    end else if (bus.imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_target;
                        if (bus.imem_rsp_valid) begin
                            // The in-flight word dies now; nothing left to kill
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_kill  <= 1'b1;
                        end
                    end else if (bus.imem_rsp_valid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_instr    <= bus.imem_rsp_data;
                            r_instr_pc <= r_pc;
                            r_state    <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.redirect_valid) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (bus.instr_ready) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
